// File: rtl/voice_flap_detect_pkg.sv
// Shared types and defaults for the voice-triggered flap detector.
package voice_pkg;

  localparam int unsigned SAMPLE_W     = 24;
  localparam int unsigned HOLD_W       = 32;
  localparam int unsigned WIN_LOG2_DEF = 8;
  localparam int unsigned DC_SHIFT     = 10;

  localparam logic [SAMPLE_W-1:0] TH_HI_DEF   = 24'd400000;
  localparam logic [SAMPLE_W-1:0] TH_LO_DEF   = 24'd200000;
  localparam logic [HOLD_W-1:0]   HOLDOFF_DEF = 32'd12500000;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 24'h7F_FFFF;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 24'h80_0000;

  typedef enum logic [1:0] {
    QUIET   = 2'd0,
    LOUD    = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/voice_flap_detect_if.sv
// Codec sample stream in, flap request / LED / level out.
interface voice_flap_detect_if import voice_pkg::*; ();

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;
  logic                flap;
  logic                voice_active;
  logic [SAMPLE_W-1:0] level;

  modport master (
    output sample_valid, sample_left, sample_right,
    input  flap, voice_active, level
  );

  modport slave (
    input  sample_valid, sample_left, sample_right,
    output flap, voice_active, level
  );

endinterface

// File: rtl/voice_flap_detect_sample_mag.sv
// Per-channel saturating |x|; optional DC removal when VOICE_DC_BLOCK_EN is defined.
module sample_mag import voice_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] mag_c_o
);

  logic [SAMPLE_W-1:0] chan;

`ifdef VOICE_DC_BLOCK_EN
  logic signed [SAMPLE_W-1:0] dc_q, dc_d;
  logic signed [SAMPLE_W:0]   diff;

  // Leaky DC tracker; the difference is saturated back into sample range.
  always_comb begin
    diff = $signed({sample_i[SAMPLE_W-1], sample_i}) - $signed({dc_q[SAMPLE_W-1], dc_q});
    dc_d = dc_q + SAMPLE_W'(diff >>> DC_SHIFT);
    if (!diff[SAMPLE_W] && diff[SAMPLE_W-1]) begin
      chan = SAMPLE_MAX;
    end else if (diff[SAMPLE_W] && !diff[SAMPLE_W-1]) begin
      chan = SAMPLE_MIN;
    end else begin
      chan = diff[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_q <= '0;
    end else if (valid_i) begin
      dc_q <= dc_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, valid_i};
  assign chan      = sample_i;
`endif

  // Most negative input has no positive twin; clamp it.
  always_comb begin
    if (!chan[SAMPLE_W-1]) begin
      mag_c_o = chan;
    end else if (chan == SAMPLE_MIN) begin
      mag_c_o = SAMPLE_MAX;
    end else begin
      mag_c_o = ~chan + SAMPLE_W'(1);
    end
  end

endmodule

// File: rtl/voice_flap_detect.sv
// Windowed mean-magnitude voice detector with hysteresis and refractory holdoff.
// Optional build macro: VOICE_DC_BLOCK_EN (per-channel DC removal in sample_mag).
module voice_flap_detect import voice_pkg::*; #(
  parameter int unsigned         WIN_LOG2    = WIN_LOG2_DEF,
  parameter logic [SAMPLE_W-1:0] TH_HI       = TH_HI_DEF,
  parameter logic [SAMPLE_W-1:0] TH_LO       = TH_LO_DEF,
  parameter logic [HOLD_W-1:0]   HOLDOFF_CYC = HOLDOFF_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  voice_flap_detect_if.slave   bus
);

  localparam int unsigned ACC_W = SAMPLE_W + WIN_LOG2;

  logic [SAMPLE_W-1:0] mag_l, mag_r, mag;
  logic [SAMPLE_W:0]   mag_sum;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                win_done_q, win_done_d;
  logic                lvl_upd_q;
  logic [SAMPLE_W-1:0] level_q, level_d;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                flap_q, flap_d;
  logic                va_q, va_d;

  sample_mag u_mag_l (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .valid_i  (bus.sample_valid),
    .sample_i (bus.sample_left),
    .mag_c_o  (mag_l)
  );

  sample_mag u_mag_r (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .valid_i  (bus.sample_valid),
    .sample_i (bus.sample_right),
    .mag_c_o  (mag_r)
  );

  assign mag_sum = {1'b0, mag_l} + {1'b0, mag_r};
  assign mag     = mag_sum[SAMPLE_W:1];

  // Accumulate; on the cycle after the window closes, publish the mean and restart.
  always_comb begin
    acc_d      = win_done_q ? '0 : acc_q;
    cnt_d      = cnt_q;
    win_done_d = 1'b0;
    level_d    = level_q;
    if (win_done_q) begin
      level_d = SAMPLE_W'(acc_q >> WIN_LOG2);
    end
    if (bus.sample_valid) begin
      acc_d      = acc_d + ACC_W'(mag);
      cnt_d      = cnt_q + WIN_LOG2'(1);
      win_done_d = (cnt_q == '1);
    end
  end

  // Thresholds are only looked at right after a fresh level.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    flap_d  = 1'b0;
    case (state_q)
      QUIET: begin
        if (lvl_upd_q && (level_q > TH_HI)) begin
          state_d = LOUD;
          flap_d  = 1'b1;
        end
      end
      LOUD: begin
        if (lvl_upd_q && (level_q < TH_LO)) begin
          state_d = HOLDOFF;
          hold_d  = HOLDOFF_CYC;
        end
      end
      HOLDOFF: begin
        hold_d = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          state_d = QUIET;
        end
      end
      default: state_d = QUIET;
    endcase
    va_d = (state_d == LOUD);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      win_done_q <= 1'b0;
      lvl_upd_q  <= 1'b0;
      level_q    <= '0;
      state_q    <= QUIET;
      hold_q     <= '0;
      flap_q     <= 1'b0;
      va_q       <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      win_done_q <= win_done_d;
      lvl_upd_q  <= win_done_q;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      flap_q     <= flap_d;
      va_q       <= va_d;
    end
  end

  assign bus.flap         = flap_q;
  assign bus.voice_active = va_q;
  assign bus.level        = level_q;

endmodule

// File: doc/voice_flap_detect.md
VOICE_FLAP_DETECT -- requirements
Module: voice_flap_detect

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 8, giving the averaging window as 2^WIN_LOG2 samples.
REQ-002 The block SHALL have parameter TH_HI, default 24'd400000, the loud-entry level threshold.
REQ-003 The block SHALL have parameter TH_LO, default 24'd200000, the loud-exit level threshold; TH_LO SHALL be less than TH_HI.
REQ-004 The block SHALL have parameter HOLDOFF_CYC, default 32'd12500000, the refractory time in clock cycles (0.25 s at 50 MHz).
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit, the only clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port sample_valid, input, 1 bit, which strobes high for one cycle per codec sample pair.
REQ-008 The block SHALL have ports sample_left and sample_right, inputs, 24 bits each, carrying signed two's-complement codec samples.
REQ-009 The block SHALL have port flap, output, 1 bit, a single-cycle flap request to the bird.
REQ-010 The block SHALL have port voice_active, output, 1 bit, which drives the LED and is high in state LOUD.
REQ-011 The block SHALL have port level, output, 24 bits, carrying the unsigned windowed mean magnitude.

Function
REQ-012 The block SHALL ignore sample_left and sample_right on any cycle where sample_valid is low.
REQ-013 The block SHALL compute each channel magnitude as |x|, saturating -2^23 to 2^23-1.
REQ-014 The block SHALL compute mag as (|L|+|R|)>>1, using a 25-bit intermediate sum and producing a 24-bit result.
REQ-015 The block SHALL add mag into an accumulator of 24+WIN_LOG2 bits and increment a WIN_LOG2-bit sample counter on each valid sample.
REQ-016 When the counter wraps, with the sample at count 2^WIN_LOG2-1 included, the block SHALL register level as acc>>WIN_LOG2 on the next cycle and clear acc in that same cycle.
REQ-017 The FSM SHALL have exactly three states, QUIET, LOUD and HOLDOFF, and SHALL evaluate thresholds only in the cycle after a level update.
REQ-018 In QUIET, when level > TH_HI, the FSM SHALL go to LOUD and assert flap for exactly one cycle, two cycles after the window-completing sample_valid.
REQ-019 In LOUD, when level < TH_LO, the FSM SHALL go to HOLDOFF and load the holdoff counter with HOLDOFF_CYC.
REQ-020 In LOUD, when level >= TH_LO, the FSM SHALL stay in LOUD and SHALL NOT emit any further flap.
REQ-021 In HOLDOFF, the block SHALL decrement the counter every cycle, ignore level, and go to QUIET on the cycle the counter reaches 0.
REQ-022 If HOLDOFF_CYC is 0, the FSM SHALL spend exactly one cycle in HOLDOFF.
REQ-023 In QUIET, a level exactly equal to TH_HI SHALL NOT trigger; in LOUD, a level exactly equal to TH_LO SHALL hold the FSM in LOUD.
REQ-024 The block SHALL continue windowing in all FSM states, and the window SHALL never stall.

Reset
REQ-025 While reset_n is low, the block SHALL force state QUIET, acc=0, counter=0, level=0, holdoff counter=0, flap=0 and voice_active=0, with no clock required.
REQ-026 When reset_n is asserted mid-window or mid-holdoff, the block SHALL discard the partial window and remaining holdoff, and the first window after release SHALL start at sample 0.
REQ-027 The block SHALL sample no input on the release edge of reset_n; the first valid sample SHALL be taken on the first rising clock with reset_n high.

Configuration
REQ-028 Macro VOICE_DC_BLOCK_EN SHALL select per-channel DC removal before the magnitude stage.
REQ-029 With VOICE_DC_BLOCK_EN defined, the block SHALL track dc <= dc + ((x-dc)>>>10) on each valid sample, use x-dc saturated to 24 bits as the channel value, and reset dc to 0.
REQ-030 Without VOICE_DC_BLOCK_EN, the block SHALL use raw samples, include no dc registers, and add no latency.

Structure
REQ-031 Package voice_pkg SHALL hold SAMPLE_W=24, the state enum typedef (QUIET, LOUD, HOLDOFF), and the default threshold and holdoff constants.
REQ-032 Sub-module sample_mag SHALL perform the per-channel saturating absolute value, plus the DC block when enabled, and SHALL be instantiated twice.

Verification
REQ-033 With WIN_LOG2=2, the bench SHALL apply samples L=R=1000 ×4 and check level=1000 one cycle after the 4th valid, with flap=0.
REQ-034 With WIN_LOG2=2, TH_HI=500, TH_LO=200 and HOLDOFF_CYC=10, the bench SHALL apply a loud window (L=-800, R=800), then four windows of 0, and check one flap pulse, then voice_active falling, then QUIET exactly 10 cycles after HOLDOFF entry.
REQ-035 The bench SHALL keep a loud signal for 20 windows and check exactly one flap pulse.
REQ-036 The bench SHALL apply a second loud window during HOLDOFF and check no flap, followed by a fresh flap only after the return to QUIET.
REQ-037 The bench SHALL apply L=R=-2^23 and check mag=2^23-1 with no wrap.
REQ-038 The bench SHALL drop reset_n asynchronously mid-window between clock edges and check all outputs are 0 immediately and that the next window counts 4 fresh samples.
